data_bus_arbiter: RTL and testbench

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/data_bus_arbiter_if.sv | 29 ++
 rtl/data_bus_arbiter.sv | 107 ++++++++++
 tb/tb_data_bus_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// Request/response signals for the two requesters plus the shared data bus.
// master: the arbiter side; slave: requesters and the address decoder/read mux.
interface data_bus_arbiter_if;
    logic        r0_valid, r1_valid;
    logic [31:0] r0_addr, r1_addr;
    logic        r0_write, r1_write;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_accept, r1_accept;
    logic        r0_done, r1_done;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] bus_address;
    logic        bus_read_en, bus_write_en;
    logic [31:0] bus_write_value;
    logic [31:0] bus_read_value;

    modport master (
        input  r0_valid, r1_valid, r0_addr, r1_addr, r0_write, r1_write,
               r0_wdata, r1_wdata, bus_read_value,
        output r0_accept, r1_accept, r0_done, r1_done, r0_rdata, r1_rdata,
               bus_address, bus_read_en, bus_write_en, bus_write_value
    );

    modport slave (
        output r0_valid, r1_valid, r0_addr, r1_addr, r0_write, r1_write,
               r0_wdata, r1_wdata, bus_read_value,
        input  r0_accept, r1_accept, r0_done, r1_done, r0_rdata, r1_rdata,
               bus_address, bus_read_en, bus_write_en, bus_write_value
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter for a single data bus. One access is in
// flight at a time: IDLE grants, ACCESS holds the strobes for a wait count
// chosen by address bit 31 (IO vs memory), DONE pulses the owner's done.
module data_bus_arbiter #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    data_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] MEM_W = 4'(MEM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q;
    logic            pref_q;      // requester favoured when both are valid
    logic            owner_q;
    logic            wr_q;
    logic [31:0]     addr_q, wdata_q;
    logic [1:0][31:0] rdata_q;

    logic [1:0]  req_v;
    logic        grant;
    logic [31:0] g_addr, g_wdata;
    logic        g_write;
    logic [3:0]  g_wait;
    logic        start, finish, rd_en, wr_en;

    // Pick the requester: a lone valid wins outright, a tie goes to pref_q.
    always_comb begin
        req_v   = {bus.r1_valid, bus.r0_valid};
        grant   = req_v[1] & (~req_v[0] | pref_q);
        g_addr  = grant ? bus.r1_addr  : bus.r0_addr;
        g_wdata = grant ? bus.r1_wdata : bus.r0_wdata;
        g_write = grant ? bus.r1_write : bus.r0_write;
        g_wait  = g_addr[31] ? IO_W : MEM_W;
    end

    // Next state and strobes; accept is held off while reset is asserted.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|req_v) && !rst) begin
                    start   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rd_en = ~wr_q;
                wr_en = wr_q;
                if (cnt_q <= 4'd1) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, capture of the granted request, wait counter and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pref_q  <= 1'b0;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                owner_q <= grant;
                pref_q  <= ~grant;
                addr_q  <= g_addr;
                wdata_q <= g_wdata;
                wr_q    <= g_write;
                cnt_q   <= g_wait;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (finish && !wr_q)
                rdata_q[owner_q] <= bus.bus_read_value;
        end
    end

    assign bus.r0_accept       = start & ~grant;
    assign bus.r1_accept       = start &  grant;
    assign bus.r0_done         = (state_q == DONE) & ~owner_q;
    assign bus.r1_done         = (state_q == DONE) &  owner_q;
    assign bus.r0_rdata        = rdata_q[0];
    assign bus.r1_rdata        = rdata_q[1];
    assign bus.bus_address     = addr_q;
    assign bus.bus_write_value = wdata_q;
    assign bus.bus_read_en     = rd_en;
    assign bus.bus_write_en    = wr_en;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed per-cycle vector table for data_bus_arbiter (MEM_WAIT=1,
// IO_WAIT=3), followed by a round-robin run with both requesters held valid.
module tb_data_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_bus_arbiter_if bif ();

    data_bus_arbiter #(.MEM_WAIT(1), .IO_WAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  v, w;
        logic [31:0] a0, a1, d0, d1, rv;
        logic [1:0]  acc, dn;
        logic        re, we;
        logic [31:0] ba, bw, rd0, rd1;
    } vec_t;

    vec_t tv[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] v, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] rv,
                       input logic [1:0] acc, input logic [1:0] dn,
                       input logic re, input logic we, input logic [31:0] ba,
                       input logic [31:0] bw, input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t t;
        t.rst = r; t.v = v; t.w = w; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.rv = rv; t.acc = acc; t.dn = dn; t.re = re; t.we = we; t.ba = ba;
        t.bw = bw; t.rd0 = rd0; t.rd1 = rd1;
        tv.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        rst                 = t.rst;
        bif.r0_valid        = t.v[0];
        bif.r1_valid        = t.v[1];
        bif.r0_write        = t.w[0];
        bif.r1_write        = t.w[1];
        bif.r0_addr         = t.a0;
        bif.r1_addr         = t.a1;
        bif.r0_wdata        = t.d0;
        bif.r1_wdata        = t.d1;
        bif.bus_read_value  = t.rv;
    endtask

    initial begin
        int   acc_cyc[$];
        int   acc_who[$];
        int   cyc;
        vec_t idle;

        idle.rst = 1'b1; idle.v = '0; idle.w = '0; idle.a0 = '0; idle.a1 = '0;
        idle.d0 = '0; idle.d1 = '0; idle.rv = '0;
        idle.acc = '0; idle.dn = '0; idle.re = 1'b0; idle.we = 1'b0;
        idle.ba = '0; idle.bw = '0; idle.rd0 = '0; idle.rd1 = '0;
        drive(idle);
        repeat (2) @(posedge clk);

        //  rst  v      w      a0            a1            d0          d1          rv            acc    dn     re  we  ba            bw          rd0           rd1
        // reset state, valid ignored while in reset
        add(1, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h0,        2'b00, 2'b00, 0, 0, 32'h0,        32'h0,      32'h0,        32'h0);
        add(1, 2'b11, 2'b00, 32'h100,      32'h300,      32'h0,      32'h0,      32'h0,        2'b00, 2'b00, 0, 0, 32'h0,        32'h0,      32'h0,        32'h0);
        // r0 memory read 0x100; drops valid and changes addr after accept
        add(0, 2'b01, 2'b00, 32'h100,      32'h0,        32'h0,      32'h0,      32'h0,        2'b01, 2'b00, 0, 0, 32'h0,        32'h0,      32'h0,        32'h0);
        add(0, 2'b00, 2'b00, 32'h999,      32'h0,        32'h0,      32'h0,      32'hDEADBEEF, 2'b00, 2'b00, 1, 0, 32'h100,      32'h0,      32'h0,        32'h0);
        add(0, 2'b00, 2'b00, 32'h999,      32'h0,        32'h0,      32'h0,      32'h0,        2'b00, 2'b01, 0, 0, 32'h100,      32'h0,      32'hDEADBEEF, 32'h0);
        // r1 IO write 0x8000_0004 <= 0x55, three strobe cycles
        add(0, 2'b10, 2'b10, 32'h0,        32'h80000004, 32'h0,      32'h55,     32'h0,        2'b10, 2'b00, 0, 0, 32'h100,      32'h0,      32'hDEADBEEF, 32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h1234,     2'b00, 2'b00, 0, 1, 32'h80000004, 32'h55,     32'hDEADBEEF, 32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h1234,     2'b00, 2'b00, 0, 1, 32'h80000004, 32'h55,     32'hDEADBEEF, 32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h1234,     2'b00, 2'b00, 0, 1, 32'h80000004, 32'h55,     32'hDEADBEEF, 32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h1234,     2'b00, 2'b10, 0, 0, 32'h80000004, 32'h55,     32'hDEADBEEF, 32'h0);
        // both valid: r1 went last so r0 wins, then r1, then r0
        add(0, 2'b11, 2'b00, 32'h200,      32'h300,      32'h0,      32'h0,      32'h0,        2'b01, 2'b00, 0, 0, 32'h80000004, 32'h55,     32'hDEADBEEF, 32'h0);
        add(0, 2'b11, 2'b00, 32'h200,      32'h300,      32'h0,      32'h0,      32'hA0A0A0A0, 2'b00, 2'b00, 1, 0, 32'h200,      32'h0,      32'hDEADBEEF, 32'h0);
        add(0, 2'b11, 2'b00, 32'h200,      32'h300,      32'h0,      32'h0,      32'h0,        2'b00, 2'b01, 0, 0, 32'h200,      32'h0,      32'hA0A0A0A0, 32'h0);
        add(0, 2'b11, 2'b00, 32'h200,      32'h300,      32'h0,      32'h0,      32'h0,        2'b10, 2'b00, 0, 0, 32'h200,      32'h0,      32'hA0A0A0A0, 32'h0);
        add(0, 2'b11, 2'b00, 32'h200,      32'h300,      32'h0,      32'h0,      32'hB1B1B1B1, 2'b00, 2'b00, 1, 0, 32'h300,      32'h0,      32'hA0A0A0A0, 32'h0);
        add(0, 2'b11, 2'b00, 32'h200,      32'h300,      32'h0,      32'h0,      32'h0,        2'b00, 2'b10, 0, 0, 32'h300,      32'h0,      32'hA0A0A0A0, 32'hB1B1B1B1);
        add(0, 2'b11, 2'b00, 32'h200,      32'h300,      32'h0,      32'h0,      32'h0,        2'b01, 2'b00, 0, 0, 32'h300,      32'h0,      32'hA0A0A0A0, 32'hB1B1B1B1);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'hC2C2C2C2, 2'b00, 2'b00, 1, 0, 32'h200,      32'h0,      32'hA0A0A0A0, 32'hB1B1B1B1);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h0,        2'b00, 2'b01, 0, 0, 32'h200,      32'h0,      32'hC2C2C2C2, 32'hB1B1B1B1);
        // r1 IO read, reset during its second strobe cycle
        add(0, 2'b10, 2'b00, 32'h0,        32'h80000010, 32'h0,      32'h0,      32'h0,        2'b10, 2'b00, 0, 0, 32'h200,      32'h0,      32'hC2C2C2C2, 32'hB1B1B1B1);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'hEEEE,     2'b00, 2'b00, 1, 0, 32'h80000010, 32'h0,      32'hC2C2C2C2, 32'hB1B1B1B1);
        add(1, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'hEEEE,     2'b00, 2'b00, 1, 0, 32'h80000010, 32'h0,      32'hC2C2C2C2, 32'hB1B1B1B1);
        // after reset: everything cleared, tie goes to r0
        add(0, 2'b11, 2'b00, 32'h400,      32'h500,      32'h0,      32'h0,      32'hEEEE,     2'b01, 2'b00, 0, 0, 32'h0,        32'h0,      32'h0,        32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h77,       2'b00, 2'b00, 1, 0, 32'h400,      32'h0,      32'h0,        32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h0,        2'b00, 2'b01, 0, 0, 32'h400,      32'h0,      32'h77,       32'h0);
        // r0 memory write leaves its rdata untouched
        add(0, 2'b01, 2'b01, 32'h40,       32'h0,        32'hCAFE,   32'h0,      32'h0,        2'b01, 2'b00, 0, 0, 32'h400,      32'h0,      32'h77,       32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h999,      2'b00, 2'b00, 0, 1, 32'h40,       32'hCAFE,   32'h77,       32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h999,      2'b00, 2'b01, 0, 0, 32'h40,       32'hCAFE,   32'h77,       32'h0);
        add(0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,      32'h0,      32'h0,        2'b00, 2'b00, 0, 0, 32'h40,       32'hCAFE,   32'h77,       32'h0);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("v%0d accept", i), {30'd0, bif.r1_accept, bif.r0_accept}, {30'd0, tv[i].acc});
            chk($sformatf("v%0d done", i),   {30'd0, bif.r1_done, bif.r0_done},     {30'd0, tv[i].dn});
            chk($sformatf("v%0d read_en", i),  {31'd0, bif.bus_read_en},  {31'd0, tv[i].re});
            chk($sformatf("v%0d write_en", i), {31'd0, bif.bus_write_en}, {31'd0, tv[i].we});
            chk($sformatf("v%0d address", i),  bif.bus_address,     tv[i].ba);
            chk($sformatf("v%0d wvalue", i),   bif.bus_write_value, tv[i].bw);
            chk($sformatf("v%0d r0_rdata", i), bif.r0_rdata,        tv[i].rd0);
            chk($sformatf("v%0d r1_rdata", i), bif.r1_rdata,        tv[i].rd1);
        end

        // Both requesters valid straight out of reset: grants alternate
        // r0,r1,... with MEM_WAIT+2 = 3 cycles between accepts.
        @(negedge clk);
        drive(idle);
        bif.r0_valid = 1'b1; bif.r1_valid = 1'b1;
        bif.r0_addr  = 32'h10; bif.r1_addr = 32'h14;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (acc_cyc.size() < 8 && cyc < 60) begin
            #1;
            if (bif.r0_accept || bif.r1_accept) begin
                acc_cyc.push_back(cyc);
                acc_who.push_back(bif.r1_accept ? 1 : 0);
            end
            if ((bif.r0_accept && bif.r1_accept) || ((bif.r0_accept || bif.r1_accept) && (bif.r0_done || bif.r1_done)))
                chk($sformatf("rr overlap c%0d", cyc), 32'd1, 32'd0);
            @(negedge clk);
            cyc++;
        end
        chk("rr accept count", acc_cyc.size(), 8);
        if (acc_cyc.size() > 0) chk("rr first accept cycle", acc_cyc[0], 0);
        for (int k = 0; k < acc_cyc.size(); k++) begin
            chk($sformatf("rr owner %0d", k), acc_who[k], k % 2);
            if (k > 0) chk($sformatf("rr spacing %0d", k), acc_cyc[k] - acc_cyc[k-1], 3);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
